// File: rtl/apb_slave_regfile.sv
// APB register-file slave: register 0 is a read-only ID, registers 1..NUM_REGS-1 are read/write.
// Transfers complete after a programmable number of wait states; register 1 drives CTRL_OUT.
module apb_slave_regfile #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 16,
  parameter int unsigned           WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA5B0_0001)
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR,
  output logic [DATA_WIDTH-1:0]   CTRL_OUT
);

  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic                    pready_q, pready_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic [ADDR_WIDTH-1:0]   x_addr;
  logic                    x_write;
  logic [DATA_WIDTH-1:0]   x_wdata;
  logic [STRB_W-1:0]       x_strb;
  logic [IDX_W-1:0]        x_idx;
  logic                    x_err;
  logic                    complete;

  // Transfer being completed: live bus in a zero-wait setup, latched copy otherwise
  always_comb begin
    x_addr  = addr_q;
    x_write = write_q;
    x_wdata = wdata_q;
    x_strb  = strb_q;
    if (state_q == S_IDLE) begin
      x_addr  = PADDR;
      x_write = PWRITE;
      x_wdata = PWDATA;
      x_strb  = PSTRB;
    end
    x_idx = x_addr[IDX_W+1:2];
    x_err = (x_addr[1:0] != 2'b00) || (x_addr >= ADDR_LIMIT) ||
            (x_write && (x_idx == '0));
  end

  // Next-state, wait counter, response and register-update logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    regs_d    = regs_q;
    complete  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d   = PADDR;
          write_d  = PWRITE;
          wdata_d  = PWDATA;
          strb_d   = PSTRB;
          cnt_d    = CNT_W'(WAIT_CYCLES);
          state_d  = S_ACCESS;
          complete = (WAIT_CYCLES == 0);
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          // PREADY cycle: transfer finished, free for a new setup next cycle
          state_d = S_IDLE;
        end else if (!PSEL) begin
          // requester dropped the transfer during wait states
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          complete = (cnt_q == CNT_W'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      pready_d  = 1'b1;
      pslverr_d = x_err;
      if (!x_err) begin
        if (x_write) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (x_strb[b]) regs_d[x_idx][8*b +: 8] = x_wdata[8*b +: 8];
          end
        end else begin
          prdata_d = (x_idx == '0) ? ID_VALUE : regs_q[x_idx];
        end
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  assign PREADY   = pready_q;
  assign PRDATA   = prdata_q;
  assign PSLVERR  = pslverr_q;
  assign CTRL_OUT = regs_q[1];

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one instance with one wait state, one with zero.
module tb_apb_slave_regfile;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel0, psel1, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic [31:0] prdata0, prdata1, ctrl0, ctrl1;

  int n_chk = 0;
  int n_bad = 0;

  always #5 pclk = ~pclk;

  apb_slave_regfile #(.WAIT_CYCLES(1)) u_dut1 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready1), .PRDATA(prdata1),
    .PSLVERR(pslverr1), .CTRL_OUT(ctrl1)
  );

  apb_slave_regfile #(.WAIT_CYCLES(0)) u_dut0 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready0), .PRDATA(prdata0),
    .PSLVERR(pslverr0), .CTRL_OUT(ctrl0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One APB transfer; zw selects the zero-wait instance. Returns at the negedge of the PREADY cycle.
  task automatic xfer(input bit zw, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                      output int lat);
    bit done;
    @(posedge pclk); #1;
    psel0 = zw; psel1 = !zw; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    done = 1'b0; lat = 0; rdata = '0; err = 1'b0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge pclk);
      if (zw ? pready0 : pready1) begin
        lat   = c;
        rdata = zw ? prdata0 : prdata1;
        err   = zw ? pslverr0 : pslverr1;
        done  = 1'b1;
      end else begin
        chk("wait_prdata", zw ? prdata0 : prdata1, 32'h0);
        chk("wait_pslverr", 32'(zw ? pslverr0 : pslverr1), 32'h0);
        @(posedge pclk); #1;
      end
    end
    if (!done) chk("xfer_timeout", 32'(done), 32'h1);
  endtask

  task automatic bus_idle();
    @(posedge pclk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    preset = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_pready", 32'(pready1), 32'h0);
    chk("rst_prdata", prdata1, 32'h0);
    chk("rst_pslverr", 32'(pslverr1), 32'h0);
    chk("rst_ctrl", ctrl1, 32'h0);
    chk("rst_ctrl0", ctrl0, 32'h0);
    @(posedge pclk); #1;
    preset = 1'b0;

    // one-wait write to register 1, then CTRL_OUT one cycle after PREADY
    xfer(0, 1, 32'h04, 32'h1234_5678, 4'hF, rd, er, lat);
    chk("wr04_lat", 32'(lat), 32'd2);
    chk("wr04_err", 32'(er), 32'h0);
    bus_idle();
    @(negedge pclk);
    chk("wr04_ctrl", ctrl1, 32'h1234_5678);
    xfer(0, 0, 32'h04, 32'h0, 4'hF, rd, er, lat);
    chk("rd04_data", rd, 32'h1234_5678);
    chk("rd04_lat", 32'(lat), 32'd2);

    // ID register is read-only
    xfer(0, 0, 32'h00, 32'h0, 4'hF, rd, er, lat);
    chk("rd00_data", rd, 32'hA5B0_0001);
    chk("rd00_err", 32'(er), 32'h0);
    xfer(0, 1, 32'h00, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    chk("wr00_err", 32'(er), 32'h1);
    chk("wr00_prdata", rd, 32'h0);
    xfer(0, 0, 32'h00, 32'h0, 4'hF, rd, er, lat);
    chk("rd00_again", rd, 32'hA5B0_0001);

    // byte strobes
    xfer(0, 1, 32'h08, 32'hFFFF_FFFF, 4'b0101, rd, er, lat);
    chk("wr08_err", 32'(er), 32'h0);
    xfer(0, 0, 32'h08, 32'h0, 4'hF, rd, er, lat);
    chk("rd08_strb", rd, 32'h00FF_00FF);
    xfer(0, 1, 32'h08, 32'h1111_1111, 4'b0000, rd, er, lat);
    chk("wr08_nostrb_err", 32'(er), 32'h0);
    xfer(0, 0, 32'h08, 32'h0, 4'b0000, rd, er, lat);
    chk("rd08_nostrb", rd, 32'h00FF_00FF);

    // address errors
    xfer(0, 0, 32'h40, 32'h0, 4'hF, rd, er, lat);
    chk("rd40_err", 32'(er), 32'h1);
    chk("rd40_data", rd, 32'h0);
    xfer(0, 0, 32'h06, 32'h0, 4'hF, rd, er, lat);
    chk("rd06_err", 32'(er), 32'h1);
    chk("rd06_data", rd, 32'h0);
    xfer(0, 1, 32'h06, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    chk("wr06_err", 32'(er), 32'h1);
    xfer(0, 1, 32'h44, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    chk("wr44_err", 32'(er), 32'h1);
    xfer(0, 0, 32'h04, 32'h0, 4'hF, rd, er, lat);
    chk("rd04_after_err", rd, 32'h1234_5678);
    xfer(0, 0, 32'h3C, 32'h0, 4'hF, rd, er, lat);
    chk("rd3c_err", 32'(er), 32'h0);
    chk("rd3c_data", rd, 32'h0);

    // access phase without setup is ignored
    bus_idle();
    @(posedge pclk); #1;
    psel1 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h0; pstrb = 4'hF;
    repeat (3) begin
      @(negedge pclk);
      chk("nosetup_pready", 32'(pready1), 32'h0);
    end
    bus_idle();
    xfer(0, 0, 32'h04, 32'h0, 4'hF, rd, er, lat);
    chk("rd04_after_nosetup", rd, 32'h1234_5678);

    // abort during wait state
    bus_idle();
    @(posedge pclk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    @(posedge pclk); #1;
    psel1 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("abort_pready_a", 32'(pready1), 32'h0);
    @(negedge pclk);
    chk("abort_pready_b", 32'(pready1), 32'h0);
    xfer(0, 0, 32'h0C, 32'h0, 4'hF, rd, er, lat);
    chk("rd0c_after_abort", rd, 32'h0);

    // reset in a wait state of a write to register 1
    bus_idle();
    @(posedge pclk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hAAAA_5555; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(negedge pclk);
    chk("rstwait_pready_a", 32'(pready1), 32'h0);
    @(posedge pclk); #1;
    preset = 1'b0; psel1 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("rstwait_pready_b", 32'(pready1), 32'h0);
    chk("rstwait_ctrl", ctrl1, 32'h0);
    xfer(0, 0, 32'h04, 32'h0, 4'hF, rd, er, lat);
    chk("rstwait_rd04", rd, 32'h0);
    xfer(0, 1, 32'h04, 32'h0000_BEEF, 4'hF, rd, er, lat);
    chk("rstwait_wr_lat", 32'(lat), 32'd2);
    chk("rstwait_wr_err", 32'(er), 32'h0);

    // back-to-back on the one-wait instance
    xfer(0, 1, 32'h10, 32'h1357_2468, 4'hF, rd, er, lat);
    chk("b2b1_wr_lat", 32'(lat), 32'd2);
    xfer(0, 0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    chk("b2b1_rd_lat", 32'(lat), 32'd2);
    chk("b2b1_rd_data", rd, 32'h1357_2468);
    xfer(0, 0, 32'h04, 32'h0, 4'hF, rd, er, lat);
    chk("b2b1_rd04", rd, 32'h0000_BEEF);

    // zero-wait instance, back-to-back
    bus_idle();
    xfer(1, 1, 32'h0C, 32'h5A5A_1234, 4'hF, rd, er, lat);
    chk("zw_wr_lat", 32'(lat), 32'd1);
    chk("zw_wr_err", 32'(er), 32'h0);
    xfer(1, 0, 32'h0C, 32'h0, 4'hF, rd, er, lat);
    chk("zw_rd_lat", 32'(lat), 32'd1);
    chk("zw_rd_data", rd, 32'h5A5A_1234);
    xfer(1, 0, 32'h00, 32'h0, 4'hF, rd, er, lat);
    chk("zw_rd00", rd, 32'hA5B0_0001);
    xfer(1, 0, 32'h06, 32'h0, 4'hF, rd, er, lat);
    chk("zw_rd06_err", 32'(er), 32'h1);
    bus_idle();
    @(negedge pclk);
    chk("zw_idle_pready", 32'(pready0), 32'h0);
    xfer(0, 0, 32'h0C, 32'h0, 4'hF, rd, er, lat);
    chk("dut1_0c_untouched", rd, 32'h0);
    bus_idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, PADDR width.
REQ-002 Parameter DATA_WIDTH, default 32, PWDATA/PRDATA width and register width.
REQ-003 Parameter NUM_REGS, default 16, number of word registers, power of two, 2..256.
REQ-004 Parameter WAIT_CYCLES, default 1, wait states inserted before PREADY, 0..15.
REQ-005 Parameter ID_VALUE, default 32'hA5B0_0001, constant returned by register 0.
REQ-006 PCLK  input  1  sole clock; all logic on rising edge.
REQ-007 PRESET  input  1  reset, synchronous, active-high.
REQ-008 PSEL  input  1  slave select from APB requester.
REQ-009 PENABLE  input  1  access-phase indicator.
REQ-010 PWRITE  input  1  1 = write, 0 = read.
REQ-011 PADDR  input  ADDR_WIDTH  byte address.
REQ-012 PWDATA  input  DATA_WIDTH  write data.
REQ-013 PSTRB  input  DATA_WIDTH/8  byte write strobes.
REQ-014 PREADY  output  1  transfer complete, registered.
REQ-015 PRDATA  output  DATA_WIDTH  read data, registered, valid only while PREADY=1.
REQ-016 PSLVERR  output  1  error response, registered, valid only while PREADY=1.
REQ-017 CTRL_OUT  output  DATA_WIDTH  live contents of register 1.

Function
REQ-018 Two-state FSM, IDLE and ACCESS, with a 4-bit wait counter.
REQ-019 IDLE: PSEL=1 and PENABLE=0 (setup phase) -> latch PADDR, PWRITE, PWDATA, PSTRB, load counter with WAIT_CYCLES, go ACCESS.
REQ-020 IDLE: PSEL=1 and PENABLE=1 without a preceding setup -> ignored; stay IDLE, PREADY stays 0.
REQ-021 ACCESS: counter decrements by 1 per cycle while non-zero; PREADY=1 in exactly the cycle in which the counter equals 0.
REQ-022 Latency: PREADY=1 in access-phase cycle WAIT_CYCLES+1 (first PENABLE-high cycle = cycle 1); WAIT_CYCLES=0 gives a zero-wait transfer.
REQ-023 PREADY is high for exactly one cycle per transfer; FSM returns to IDLE on the following edge.
REQ-024 The cycle after PREADY=1 is accepted as a new setup phase (back-to-back transfers, no idle cycle required).
REQ-025 Register index = latched PADDR[log2(NUM_REGS)+1:2].
REQ-026 Error condition: PADDR[1:0]!=0, or PADDR >= NUM_REGS*4, or write to register 0.
REQ-027 Error transfer: PSLVERR=1 with PREADY, PRDATA=0, no register modified.
REQ-028 Valid write: on the PREADY edge, each byte lane with PSTRB=1 is updated from latched PWDATA; other lanes unchanged; PSTRB=0 performs no update, PSLVERR=0.
REQ-029 Valid read: PRDATA = register contents at PREADY, register 0 returns ID_VALUE; PSTRB ignored.
REQ-030 Abort: PSEL=0 while in ACCESS before PREADY -> return IDLE next edge, no write, PREADY not asserted.
REQ-031 PRDATA and PSLVERR are 0 whenever PREADY=0.
REQ-032 CTRL_OUT reflects register 1 one cycle after its write edge.

Reset
REQ-033 PRESET=1 at a rising edge: FSM -> IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0, registers 1..NUM_REGS-1 = 0, CTRL_OUT=0.
REQ-034 Reset during ACCESS aborts the transfer with no register write and no PREADY.
REQ-035 First transfer is accepted in the setup phase presented on the cycle after PRESET deasserts.

Verification
REQ-036 Write 0x1234_5678 to 0x04, PSTRB=4'hF, WAIT_CYCLES=1 -> PREADY in access cycle 2, PSLVERR=0, CTRL_OUT=0x1234_5678 one cycle later.
REQ-037 Read 0x00 -> PRDATA=0xA5B0_0001, PSLVERR=0; write 0x00 -> PSLVERR=1, subsequent read still 0xA5B0_0001.
REQ-038 Write 0xFFFF_FFFF to 0x08 with PSTRB=4'b0101 over prior 0 -> read 0x08 returns 0x00FF_00FF.
REQ-039 Read 0x40 (NUM_REGS=16) and read 0x06 -> PSLVERR=1, PRDATA=0, no register changes.
REQ-040 Back-to-back write 0x0C then read 0x0C with no idle cycle, WAIT_CYCLES=0 -> PREADY in each first access cycle, read returns written value.
REQ-041 Assert PRESET in a wait-state cycle of a write to 0x04 -> no PREADY, register 1 = 0, next transfer completes normally.
